cpu_exec_monitor: RTL and testbench

//  Synthesizable execution monitor attached beside the 16-bit CPU core. Samples PC, next PC,

---
 rtl/cpu_exec_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_exec_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_monitor.sv
// Execution monitor that sits beside the 16-bit CPU core.
// It counts sampled cycles and retirements per opcode, and detects a halt (next_pc == pc)
// or a watchdog timeout. It also keeps a circular trace of the most recent instructions.
// Once execution stops, the trace can be drained oldest-first over a valid/ready port.
module cpu_exec_monitor #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned NUM_OPC     = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRACE_DEPTH = 16,
  parameter int unsigned TIMEOUT     = 100,
  localparam int unsigned PtrW       = $clog2(TRACE_DEPTH),
  localparam int unsigned LvlW       = PtrW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    next_pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  input  logic               clear,
  output logic [1:0]         state,
  output logic               halted,
  output logic               timeout,
  output logic               overflow,
  output logic [CNT_W-1:0]   cycle_count,
  input  logic [OPC_W-1:0]   opc_sel,
  output logic [CNT_W-1:0]   opc_count,
  output logic [LvlW-1:0]    trace_level,
  output logic               trace_rd_valid,
  input  logic               trace_rd_ready,
  output logic [PC_W-1:0]    trace_rd_pc,
  output logic [INSTR_W-1:0] trace_rd_instr,
  output logic               trace_rd_zero
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2,
    StTimeout = 2'd3
  } state_e;

  localparam logic [LvlW-1:0] LvlFull = LvlW'(TRACE_DEPTH);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e state_q, state_d;

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] opc_cnt_q [NUM_OPC];
  logic [CNT_W-1:0] opc_cnt_d [NUM_OPC];
  logic [CNT_W-1:0] unk_cnt_q, unk_cnt_d;
  logic [CNT_W-1:0] opc_count_q, opc_count_d;
  logic             overflow_q, overflow_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;

  logic [PC_W-1:0]    trace_pc_q    [TRACE_DEPTH];
  logic [INSTR_W-1:0] trace_instr_q [TRACE_DEPTH];
  logic               trace_zero_q  [TRACE_DEPTH];

  logic [OPC_W-1:0] opcode;
  logic             opc_known;
  logic             active;
  logic             sample;
  logic             is_halt;
  logic [CNT_W-1:0] cycle_inc;
  logic             hit_timeout;
  logic             pop;
  logic             trace_we;
  logic [CNT_W-1:0] opc_sel_cnt;

  assign opcode    = instr[INSTR_W-1 -: OPC_W];
  assign opc_known = 32'(opcode) < NUM_OPC;
  assign active    = (state_q == StIdle) || (state_q == StRun);
  assign sample    = en && active;
  assign is_halt   = (next_pc == pc);
  assign cycle_inc = sat_inc(cycle_q);
  // Compare at 32 bits so a TIMEOUT beyond the counter range can never fire falsely.
  assign hit_timeout = (32'(cycle_inc) == TIMEOUT);
  assign pop       = trace_rd_valid && trace_rd_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: halt beats timeout on the same sample; stop states are sticky
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StRun: begin
          if (en) begin
            if (is_halt) begin
              state_d = StHalted;
            end else if (hit_timeout) begin
              state_d = StTimeout;
            end else begin
              state_d = StRun;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs; the trace is only readable once execution has stopped
  always_comb begin
    state          = state_q;
    halted         = (state_q == StHalted);
    timeout        = (state_q == StTimeout);
    trace_rd_valid = ((state_q == StHalted) || (state_q == StTimeout)) && (level_q != '0);
  end

  // Counter select for the registered opc_count readout
  always_comb begin
    opc_sel_cnt = unk_cnt_q;
    for (int unsigned i = 0; i < NUM_OPC; i++) begin
      if (opc_sel == OPC_W'(i)) begin
        opc_sel_cnt = opc_cnt_q[i];
      end
    end
  end

  // Datapath next state: counters, trace pointers and level
  always_comb begin
    cycle_d     = cycle_q;
    opc_cnt_d   = opc_cnt_q;
    unk_cnt_d   = unk_cnt_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    opc_count_d = opc_sel_cnt;
    trace_we    = 1'b0;
    if (clear) begin
      cycle_d     = '0;
      unk_cnt_d   = '0;
      overflow_d  = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      opc_count_d = '0;
      for (int unsigned i = 0; i < NUM_OPC; i++) begin
        opc_cnt_d[i] = '0;
      end
    end else if (sample) begin
      cycle_d  = cycle_inc;
      trace_we = 1'b1;
      if (opc_known) begin
        for (int unsigned i = 0; i < NUM_OPC; i++) begin
          if (opcode == OPC_W'(i)) begin
            opc_cnt_d[i] = sat_inc(opc_cnt_q[i]);
          end
        end
      end else begin
        unk_cnt_d = sat_inc(unk_cnt_q);
      end
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      // Full buffer: drop the oldest entry so the newest always lands
      if (level_q == LvlFull) begin
        rd_ptr_d   = rd_ptr_q + PtrW'(1);
        overflow_d = 1'b1;
      end else begin
        level_d = level_q + LvlW'(1);
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      level_d  = level_q - LvlW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q     <= '0;
      unk_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      opc_count_q <= '0;
      for (int unsigned i = 0; i < NUM_OPC; i++) begin
        opc_cnt_q[i] <= '0;
      end
    end else begin
      cycle_q     <= cycle_d;
      unk_cnt_q   <= unk_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      opc_count_q <= opc_count_d;
      opc_cnt_q   <= opc_cnt_d;
    end
  end

  // Trace storage; contents need no reset because the pointers define what is valid
  always_ff @(posedge clk) begin
    if (rst && trace_we) begin
      trace_pc_q[wr_ptr_q]    <= pc;
      trace_instr_q[wr_ptr_q] <= instr;
      trace_zero_q[wr_ptr_q]  <= zero_flag;
    end
  end

  // Register-backed outputs and show-ahead trace data
  always_comb begin
    overflow       = overflow_q;
    cycle_count    = cycle_q;
    opc_count      = opc_count_q;
    trace_level    = level_q;
    trace_rd_pc    = trace_pc_q[rd_ptr_q];
    trace_rd_instr = trace_instr_q[rd_ptr_q];
    trace_rd_zero  = trace_zero_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_cpu_exec_monitor.sv
// Self-checking bench for cpu_exec_monitor.
// Three parameterisations share the stimulus: a default instance, a small-trace/short-timeout
// instance and a narrow-counter instance. Each test resets all three and observes one of them.
module tb_cpu_exec_monitor;

  logic        clk = 1'b0;
  logic        rst, en, zero_flag, clear, trace_rd_ready;
  logic [7:0]  pc, next_pc;
  logic [15:0] instr;
  logic [3:0]  opc_sel;

  always #5 clk = ~clk;

  // Instance A: defaults
  logic [1:0]  a_state;
  logic        a_halted, a_timeout, a_overflow, a_valid, a_zero;
  logic [15:0] a_cycle, a_opc, a_instr;
  logic [4:0]  a_level;
  logic [7:0]  a_pc;
  // Instance B: TRACE_DEPTH=4, TIMEOUT=20
  logic [1:0]  b_state;
  logic        b_halted, b_timeout, b_overflow, b_valid, b_zero;
  logic [15:0] b_cycle, b_opc, b_instr;
  logic [2:0]  b_level;
  logic [7:0]  b_pc;
  // Instance C: CNT_W=4, TIMEOUT=1000
  logic [1:0]  c_state;
  logic        c_halted, c_timeout, c_overflow, c_valid, c_zero;
  logic [3:0]  c_cycle, c_opc;
  logic [15:0] c_instr;
  logic [4:0]  c_level;
  logic [7:0]  c_pc;

  cpu_exec_monitor u_dut_a (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .next_pc(next_pc), .instr(instr),
    .zero_flag(zero_flag), .clear(clear), .state(a_state), .halted(a_halted),
    .timeout(a_timeout), .overflow(a_overflow), .cycle_count(a_cycle), .opc_sel(opc_sel),
    .opc_count(a_opc), .trace_level(a_level), .trace_rd_valid(a_valid),
    .trace_rd_ready(trace_rd_ready), .trace_rd_pc(a_pc), .trace_rd_instr(a_instr),
    .trace_rd_zero(a_zero)
  );

  cpu_exec_monitor #(.TRACE_DEPTH(4), .TIMEOUT(20)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .next_pc(next_pc), .instr(instr),
    .zero_flag(zero_flag), .clear(clear), .state(b_state), .halted(b_halted),
    .timeout(b_timeout), .overflow(b_overflow), .cycle_count(b_cycle), .opc_sel(opc_sel),
    .opc_count(b_opc), .trace_level(b_level), .trace_rd_valid(b_valid),
    .trace_rd_ready(trace_rd_ready), .trace_rd_pc(b_pc), .trace_rd_instr(b_instr),
    .trace_rd_zero(b_zero)
  );

  cpu_exec_monitor #(.CNT_W(4), .TIMEOUT(1000)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .next_pc(next_pc), .instr(instr),
    .zero_flag(zero_flag), .clear(clear), .state(c_state), .halted(c_halted),
    .timeout(c_timeout), .overflow(c_overflow), .cycle_count(c_cycle), .opc_sel(opc_sel),
    .opc_count(c_opc), .trace_level(c_level), .trace_rd_valid(c_valid),
    .trace_rd_ready(trace_rd_ready), .trace_rd_pc(c_pc), .trace_rd_instr(c_instr),
    .trace_rd_zero(c_zero)
  );

  // Observed instance select
  int unsigned sel;
  logic [31:0] cur_state, cur_halted, cur_timeout, cur_overflow, cur_cycle, cur_opc;
  logic [31:0] cur_level, cur_valid, cur_pc, cur_instr, cur_zero;

  always_comb begin
    case (sel)
      1: begin
        cur_state = 32'(b_state);   cur_halted = 32'(b_halted); cur_timeout = 32'(b_timeout);
        cur_overflow = 32'(b_overflow); cur_cycle = 32'(b_cycle); cur_opc = 32'(b_opc);
        cur_level = 32'(b_level);   cur_valid = 32'(b_valid);   cur_pc = 32'(b_pc);
        cur_instr = 32'(b_instr);   cur_zero = 32'(b_zero);
      end
      2: begin
        cur_state = 32'(c_state);   cur_halted = 32'(c_halted); cur_timeout = 32'(c_timeout);
        cur_overflow = 32'(c_overflow); cur_cycle = 32'(c_cycle); cur_opc = 32'(c_opc);
        cur_level = 32'(c_level);   cur_valid = 32'(c_valid);   cur_pc = 32'(c_pc);
        cur_instr = 32'(c_instr);   cur_zero = 32'(c_zero);
      end
      default: begin
        cur_state = 32'(a_state);   cur_halted = 32'(a_halted); cur_timeout = 32'(a_timeout);
        cur_overflow = 32'(a_overflow); cur_cycle = 32'(a_cycle); cur_opc = 32'(a_opc);
        cur_level = 32'(a_level);   cur_valid = 32'(a_valid);   cur_pc = 32'(a_pc);
        cur_instr = 32'(a_instr);   cur_zero = 32'(a_zero);
      end
    endcase
  end

  // Scoreboard of trace entries expected to be drained, bounded like the DUT buffer
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        zero;
  } ent_t;

  ent_t sb[$];
  int   sb_depth;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    en = 1'b0; clear = 1'b0; trace_rd_ready = 1'b0; rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
  endtask

  // One enabled cycle; rec says whether the monitor is expected to record it
  task automatic do_sample(input logic [7:0] p, input logic [7:0] np, input logic [3:0] opc,
                           input logic z, input bit rec);
    en        = 1'b1;
    pc        = p;
    next_pc   = np;
    instr     = {opc, 4'hA, p};
    zero_flag = z;
    if (rec) begin
      sb.push_back('{pc: p, instr: {opc, 4'hA, p}, zero: z});
      if (sb.size() > sb_depth) void'(sb.pop_front());
    end
    tick();
    en = 1'b0;
  endtask

  task automatic drain(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      check_eq("rd_valid", cur_valid, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rd_pc", cur_pc, 32'(e.pc));
        check_eq("rd_instr", cur_instr, 32'(e.instr));
        check_eq("rd_zero", cur_zero, 32'(e.zero));
      end else begin
        check_eq("sb_nonempty", 32'd0, 32'd1);
      end
      trace_rd_ready = 1'b1;
      tick();
      trace_rd_ready = 1'b0;
    end
  endtask

  task automatic read_opc(input logic [3:0] s, input logic [31:0] exp, input string tag);
    opc_sel = s;
    tick();
    check_eq(tag, cur_opc, exp);
  endtask

  initial begin
    sel = 0; sb_depth = 16;
    rst = 1'b0; en = 1'b0; clear = 1'b0; trace_rd_ready = 1'b0; zero_flag = 1'b0;
    pc = '0; next_pc = '0; instr = '0; opc_sel = '0;

    // Reset dominates an active en
    en = 1'b1; pc = 8'd3; next_pc = 8'd4;
    tick();
    tick();
    check_eq("rst_state", cur_state, 32'd0);
    check_eq("rst_cycle", cur_cycle, 32'd0);
    check_eq("rst_level", cur_level, 32'd0);
    check_eq("rst_valid", cur_valid, 32'd0);
    en = 1'b0; rst = 1'b1;

    // Short program ending in a self-jump
    reset_all(); sel = 0; sb_depth = 16;
    for (int i = 0; i < 5; i++) do_sample(8'(i), 8'(i + 1), 4'(i), i[0], 1'b1);
    do_sample(8'd5, 8'd5, 4'd7, 1'b1, 1'b1);
    check_eq("halt_state", cur_state, 32'd2);
    check_eq("halt_flag", cur_halted, 32'd1);
    check_eq("halt_timeout", cur_timeout, 32'd0);
    check_eq("halt_cycle", cur_cycle, 32'd6);
    check_eq("halt_level", cur_level, 32'd6);
    check_eq("halt_ovf", cur_overflow, 32'd0);
    read_opc(4'd0, 32'd1, "opc0");
    read_opc(4'd4, 32'd1, "opc4");
    read_opc(4'd7, 32'd1, "opc7");
    read_opc(4'd5, 32'd0, "opc5");
    read_opc(4'd9, 32'd0, "opc_unk");
    do_sample(8'd5, 8'd6, 4'd0, 1'b0, 1'b0);
    check_eq("halt_sticky_cycle", cur_cycle, 32'd6);
    check_eq("halt_sticky_state", cur_state, 32'd2);
    drain(6);
    check_eq("drained_valid", cur_valid, 32'd0);
    check_eq("drained_level", cur_level, 32'd0);

    // Overwrite in a 4-deep trace
    reset_all(); sel = 1; sb_depth = 4;
    for (int i = 0; i < 10; i++) do_sample(8'(i), 8'(i + 1), 4'(i), i[1], 1'b1);
    do_sample(8'd10, 8'd10, 4'd7, 1'b0, 1'b1);
    check_eq("ovf_state", cur_state, 32'd2);
    check_eq("ovf_level", cur_level, 32'd4);
    check_eq("ovf_flag", cur_overflow, 32'd1);
    check_eq("ovf_cycle", cur_cycle, 32'd11);
    read_opc(4'd12, 32'd2, "ovf_unk");
    drain(4);
    check_eq("ovf_drained_valid", cur_valid, 32'd0);

    // Watchdog at 20 samples
    reset_all(); sel = 1; sb_depth = 4;
    for (int i = 0; i < 19; i++) do_sample(8'(i), 8'(i + 1), 4'd1, 1'b0, 1'b1);
    check_eq("pre_to_state", cur_state, 32'd1);
    check_eq("pre_to_flag", cur_timeout, 32'd0);
    do_sample(8'd19, 8'd20, 4'd1, 1'b1, 1'b1);
    check_eq("to_flag", cur_timeout, 32'd1);
    check_eq("to_state", cur_state, 32'd3);
    check_eq("to_halted", cur_halted, 32'd0);
    check_eq("to_cycle", cur_cycle, 32'd20);
    for (int i = 0; i < 3; i++) do_sample(8'(20 + i), 8'(21 + i), 4'd1, 1'b0, 1'b0);
    check_eq("to_sticky_cycle", cur_cycle, 32'd20);
    check_eq("to_sticky_state", cur_state, 32'd3);
    check_eq("to_sticky_level", cur_level, 32'd4);
    drain(4);
    check_eq("to_drained_valid", cur_valid, 32'd0);

    // Stall mid-run, hold off the consumer, then soft clear mid-drain
    reset_all(); sel = 0; sb_depth = 16;
    for (int i = 0; i < 3; i++) do_sample(8'(i), 8'(i + 1), 4'd2, 1'b0, 1'b1);
    en = 1'b0;
    repeat (3) tick();
    check_eq("stall_cycle", cur_cycle, 32'd3);
    check_eq("stall_level", cur_level, 32'd3);
    check_eq("stall_state", cur_state, 32'd1);
    check_eq("stall_valid", cur_valid, 32'd0);
    do_sample(8'd3, 8'd4, 4'd2, 1'b1, 1'b1);
    do_sample(8'd4, 8'd5, 4'd2, 1'b0, 1'b1);
    do_sample(8'd5, 8'd5, 4'd7, 1'b1, 1'b1);
    repeat (3) tick();
    check_eq("hold_level", cur_level, 32'd6);
    check_eq("hold_valid", cur_valid, 32'd1);
    check_eq("hold_cycle", cur_cycle, 32'd6);
    drain(3);
    check_eq("part_level", cur_level, 32'd3);
    sel = 1;
    #0;
    check_eq("b_pre_clr_ovf", cur_overflow, 32'd1);
    sel = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    check_eq("clr_state", cur_state, 32'd0);
    check_eq("clr_level", cur_level, 32'd0);
    check_eq("clr_cycle", cur_cycle, 32'd0);
    check_eq("clr_valid", cur_valid, 32'd0);
    check_eq("clr_opc", cur_opc, 32'd0);
    read_opc(4'd2, 32'd0, "clr_opc2");
    sel = 1;
    #0;
    check_eq("clr_b_ovf", cur_overflow, 32'd0);
    check_eq("clr_b_level", cur_level, 32'd0);
    check_eq("clr_b_state", cur_state, 32'd0);

    // Same again, leaving via reset instead of clear
    sel = 0; sb_depth = 16;
    for (int i = 0; i < 5; i++) do_sample(8'(i), 8'(i + 1), 4'd3, 1'b0, 1'b1);
    do_sample(8'd5, 8'd5, 4'd3, 1'b0, 1'b1);
    drain(3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    check_eq("rst2_state", cur_state, 32'd0);
    check_eq("rst2_level", cur_level, 32'd0);
    check_eq("rst2_cycle", cur_cycle, 32'd0);
    check_eq("rst2_opc", cur_opc, 32'd0);
    sel = 1;
    #0;
    check_eq("rst2_b_ovf", cur_overflow, 32'd0);

    // Saturation with 4-bit counters
    reset_all(); sel = 2; sb_depth = 16;
    for (int i = 0; i < 20; i++) do_sample(8'(i), 8'(i + 1), 4'd0, 1'b0, 1'b0);
    check_eq("sat_cycle", cur_cycle, 32'd15);
    check_eq("sat_state", cur_state, 32'd1);
    read_opc(4'd0, 32'd15, "sat_opc0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
